// File: rtl/ifu_flush_queue_if.sv
// ifu_flush_queue_if: IFU response and IDU issue handshakes around the flush queue.
interface ifu_flush_queue_if #(
    parameter int EPW  = 2,
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inst;
    logic [EPW-1:0]  in_epoch;
    logic [EPW-1:0]  cur_epoch;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;

    modport master (
        output in_valid, in_pc, in_inst, in_epoch, out_ready,
        input  in_ready, cur_epoch, out_valid, out_pc, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_epoch, out_ready,
        output in_ready, cur_epoch, out_valid, out_pc, out_inst
    );
endinterface

// File: rtl/ifu_flush_queue.sv
// ifu_flush_queue: epoch-tagged instruction queue that squashes wrong-path fetches on a BPU clear.
module ifu_flush_queue #(
    parameter int DEPTH = 4,
    parameter int EPW   = 2,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    ifu_flush_queue_if.slave       bus,
    output logic [$clog2(DEPTH):0] count,
    output logic [7:0]             drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [2*XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [EPW-1:0]    epoch;
    logic              fire_in, fire_out, wr_en, stale;

    assign bus.in_ready  = count < FULL;
    assign bus.out_valid = (count != '0) && !flush_i;
    assign bus.cur_epoch = epoch;
    assign {bus.out_pc, bus.out_inst} = mem[rd_ptr];

    assign fire_in  = bus.in_valid && bus.in_ready && !flush_i;
    assign fire_out = bus.out_valid && bus.out_ready;
    // Responses tagged with an older epoch complete the handshake but are discarded.
    assign wr_en    = fire_in && (bus.in_epoch == epoch);
    assign stale    = fire_in && (bus.in_epoch != epoch);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {bus.in_pc, bus.in_inst};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            epoch    <= '0;
            drop_cnt <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            epoch  <= epoch + EPW'(1);
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (fire_out)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(fire_out);
            if (stale && drop_cnt != 8'hff)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_ifu_flush_queue.sv
// tb_ifu_flush_queue: directed plus random checks of ifu_flush_queue against a queue-based model.
module tb_ifu_flush_queue;
    localparam int DEPTH = 4;
    localparam int EPW   = 2;
    localparam int XLEN  = 32;

    logic       clk = 0;
    logic       rst = 0;
    logic       flush_i = 0;
    logic [2:0] count;
    logic [7:0] drop_cnt;
    int         total = 0;
    int         bad = 0;

    logic [63:0] q[$];
    int          ep = 0;
    int          drop = 0;

    ifu_flush_queue_if #(.EPW(EPW), .XLEN(XLEN)) bus ();

    ifu_flush_queue #(.DEPTH(DEPTH), .EPW(EPW), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .bus(bus),
        .count(count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic cyc(bit fl, bit iv, logic [31:0] pc, logic [31:0] ins, int ie, bit ordy);
        bit rdy, ov;
        flush_i = fl;
        bus.in_valid = iv;
        bus.in_pc = pc;
        bus.in_inst = ins;
        bus.in_epoch = ie[1:0];
        bus.out_ready = ordy;
        #1;
        rdy = q.size() < DEPTH;
        ov = q.size() != 0 && !fl;
        chk("in_ready", bus.in_ready, rdy);
        chk("out_valid", bus.out_valid, ov);
        chk("count", count, q.size());
        chk("cur_epoch", bus.cur_epoch, ep);
        chk("drop_cnt", drop_cnt, drop);
        if (ov) begin
            chk("out_pc", bus.out_pc, q[0][63:32]);
            chk("out_inst", bus.out_inst, q[0][31:0]);
        end
        @(posedge clk);
        if (fl) begin
            q.delete();
            ep = (ep + 1) % 4;
        end else begin
            if (ov && ordy) void'(q.pop_front());
            if (iv && rdy) begin
                if (ie == ep) q.push_back({pc, ins});
                else if (drop < 255) drop++;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset between edges; outputs must clear before the next posedge.
    task automatic do_reset();
        #2 rst = 0;
        #1;
        q.delete();
        ep = 0;
        drop = 0;
        chk("rst_count", count, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_epoch", bus.cur_epoch, 0);
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_pc = '0;
        bus.in_inst = '0;
        bus.in_epoch = '0;
        bus.out_ready = 0;
        #3;
        chk("init_count", count, 0);
        chk("init_out_valid", bus.out_valid, 0);
        chk("init_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1;

        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h80000000 + 4*i, 32'h13 + i, 0, 0);
        chk("fill_count", count, 4);
        chk("fill_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            chk("pop_pc", bus.out_pc, 32'h80000000 + 4*i);
            cyc(0, 0, 0, 0, 0, 1);
        end

        for (int i = 0; i < 20; i++) cyc(0, 1, 32'h80000100 + 4*i, 32'h100 + i, 0, 1);
        chk("stream_count", count, 1);
        cyc(0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h80000200 + 4*i, 32'h200 + i, 0, 0);
        chk("pre_flush_count", count, 3);
        flush_i = 1;
        #1 chk("flush_out_valid", bus.out_valid, 0);
        cyc(1, 1, 32'h80000300, 32'h300, 0, 1);
        chk("post_flush_count", count, 0);
        chk("post_flush_epoch", bus.cur_epoch, 1);
        chk("post_flush_drop", drop_cnt, 0);

        cyc(0, 1, 32'h80000010, 32'h10, 0, 0);
        chk("stale_drop", drop_cnt, 1);
        chk("stale_count", count, 0);
        cyc(0, 1, 32'h80001000, 32'h1000, 1, 0);
        chk("fresh_pc", bus.out_pc, 32'h80001000);
        cyc(0, 0, 0, 0, 1, 1);

        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 1, 32'h80002000, 32'h2000, ep, 1);
        chk("wrap_epoch", bus.cur_epoch, 0);
        chk("wrap_count", count, 0);

        for (int i = 0; i < 300; i++) cyc(0, 1, 32'h80003000 + 4*i, i, (ep + 1) % 4, 0);
        chk("sat_drop", drop_cnt, 255);
        cyc(0, 1, 32'h80004000, 32'h4000, ep, 0);
        cyc(0, 1, 32'h80004004, 32'h4004, ep, 0);
        chk("mid_count", count, 2);
        do_reset();

        for (int i = 0; i < 500; i++) begin
            int ie;
            ie = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : ep;
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom, ie, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifu_flush_queue.md
Name: ifu_flush_queue

Overview:
- Instruction queue between IFU fetch responses and IDU.
- Consumes the pipeline clear pulse from BPU (bpu_clear_ctrl) and squashes all queued wrong-path instructions.
- Maintains a fetch epoch so that responses returning after a flush are discarded.
- Decouples fetch latency from decode stalls with a small circular buffer.

Parameters:
- DEPTH, 4, queue entries; power of 2, 2..16.
- EPW, 2, epoch tag width in bits.
- XLEN, 32, PC and instruction width.

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- flush_i, in, 1, pipeline clear pulse from BPU bpu_clear_ctrl; level-sampled each cycle.
- in_valid, in, 1, IFU response valid.
- in_ready, out, 1, queue can accept a response.
- in_pc, in, XLEN, PC of the fetched instruction.
- in_inst, in, XLEN, fetched instruction word.
- in_epoch, in, EPW, epoch tag IFU attached to the request.
- cur_epoch, out, EPW, current epoch; IFU tags new requests with it.
- out_valid, out, 1, head entry valid to IDU.
- out_ready, in, 1, IDU accepts head.
- out_pc, out, XLEN, head PC.
- out_inst, out, XLEN, head instruction.
- count, out, $clog2(DEPTH)+1, occupancy.
- drop_cnt, out, 8, saturating count of stale responses discarded.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr, count, cur_epoch and drop_cnt all go to 0.
  - out_valid=0 and in_ready=1 immediately.
  - Entry storage is not reset, so out_pc and out_inst are don't-care while out_valid=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH. Full is count==DEPTH; empty is count==0.
- in_ready = (count < DEPTH). It is registered state only, with no combinational path from out_ready.
- out_valid = (count != 0) && !flush_i. A flush cycle never presents an instruction to IDU.
- out_pc and out_inst come from the mem[rd_ptr] entry, read combinationally.
- Push: fire_in = in_valid && in_ready && !flush_i.
  - If in_epoch == cur_epoch, write the entry at wr_ptr and increment wr_ptr.
  - If in_epoch != cur_epoch, the response is consumed (handshake completes) but not written, and drop_cnt increments, saturating at 255.
- Pop: fire_out = out_valid && out_ready. rd_ptr increments.
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
- Push is impossible when full (in_ready=0), even if a pop happens in the same cycle. One bubble when full is accepted.
- Flush (flush_i=1 at an edge):
  - count, wr_ptr and rd_ptr go to 0.
  - cur_epoch goes to cur_epoch+1 mod 2^EPW.
  - Any in_valid that cycle is ignored: not written and not counted in drop_cnt.
  - No pop occurs.
  - A flush takes priority over every other event.
- Back-to-back flushes: each cycle increments cur_epoch; the queue stays empty.
- Latency: an instruction pushed at edge N is visible on out_valid after edge N (next cycle), provided there is no flush.
- Epoch wrap: EPW bits allow 2^EPW-1 flushes between an IFU request and its response before aliasing. IFU must bound outstanding requests accordingly; no checking is done here.
- Reset asserted mid-operation: all state clears asynchronously, regardless of flush_i or handshakes. Deassertion is synchronised externally.

Test Plan:
- Reset, then 4 pushes with epoch 0 (pc 0x80000000..0x8000000C) while out_ready=0:
  - count=4 and in_ready=0.
  - Then out_ready=1 pops the four entries in order, one per cycle, with out_pc 0x80000000, 04, 08, 0C.
- Streaming with in_valid=1 and out_ready=1 every cycle for 20 cycles: count stays 1 after the first push, and out_pc advances by 4 every cycle.
- Queue holds 3 entries, then flush_i=1 for one cycle while in_valid=1:
  - Next cycle count=0, cur_epoch=1, out_valid=0 and drop_cnt=0.
  - out_valid=0 also holds during the flush cycle itself.
- After that flush, a response with in_epoch=0 and pc 0x80000010 arrives:
  - It is accepted (in_ready=1), count stays 0, and drop_cnt=1.
  - A following response with in_epoch=1 and pc 0x80001000 appears at out_pc the next cycle.
- Four consecutive flush cycles starting at epoch 0: cur_epoch=0 afterwards (wrap with EPW=2), and the queue is empty.
- 300 stale responses: drop_cnt saturates at 255. Reset asserted mid-stream with count=2 returns count=0 and drop_cnt=0 asynchronously, before the next clock edge.
